// File: rtl/reg_dump.sv
// reg_dump: walks register indices FIRST_REG..LAST_REG through an external register file
// and streams each value out over a valid/ready handshake. Optional macro: REG_DUMP_CHECKSUM_EN.
`timescale 1ns/1ps
module reg_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, READ = 3'd1, SEND = 3'd2, CSUM = 3'd3, FIN = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, READ = 3'd1, SEND = 3'd2, FIN = 3'd4
  } state_t;
`endif

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = READ;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = 32'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        out_data_d  = rd_data;
        out_idx_d   = {1'b0, idx_q};
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        csum_d      = csum_q ^ rd_data;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // csum_q already folds in the last word, captured during its READ
            out_valid_d = 1'b1;
            out_data_d  = csum_q;
            out_idx_d   = 6'd32;
            out_last_d  = 1'b1;
            state_d     = CSUM;
`else
            state_d     = FIN;
`endif
          end
        end else begin
          state_d = SEND;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FIN;
        end else begin
          state_d = CSUM;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Address follows the next index so it is already settled when READ begins
    rd_addr_d = idx_d;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      rd_addr_q   <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_idx_q   <= 6'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
